// File: rtl/montgomery_seq_wrap_pkg.sv
// Shared types for the sequential Montgomery wrapper: FSM state encoding and
// operation-mode encodings.
package montgomery_seq_wrap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV_A = 3'd1,
        ST_CONV_B = 3'd2,
        ST_MUL    = 3'd3,
        ST_FROM   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_RAW  = 1'b1;

endpackage

// File: rtl/montgomery_mul.sv
// Digit-serial Montgomery multiplier: y = a*b*R^-1 mod m, R = 2^NBITS, with
// PBITS-bit digits of a per cycle. Operands are expected to be below m.
module montgomery_mul
    import montgomery_seq_wrap_pkg::*;
#(
    parameter int NBITS = 2048,
    parameter int PBITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    input  logic [NBITS-1:0] m_inv,
    output logic [NBITS-1:0] y,
    output logic             done_irq_p
);

    // The accumulator stays below 2m; the extra bits hold digit*b + q*m.
    localparam int TW     = NBITS + PBITS + 2;
    localparam int DIGITS = NBITS / PBITS;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    logic             r_run;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [NBITS-1:0] r_x;
    logic [NBITS-1:0] r_b;
    logic [NBITS-1:0] r_m;
    logic [NBITS-1:0] r_y;
    logic [PBITS-1:0] r_minv;
    logic [TW-1:0]    r_t;

    logic [TW-1:0]      w_m_ext;
    logic [TW-1:0]      w_sum;
    logic [TW-1:0]      w_sum2;
    logic [TW-1:0]      w_t_next;
    logic [TW-1:0]      w_red;
    logic [2*PBITS-1:0] w_qp;
    logic [PBITS-1:0]   w_q;
    logic               w_unused;

    // Only the low digit of -m^-1 mod R is needed for the per-digit quotient.
    always_comb begin
        w_m_ext  = TW'(r_m);
        w_sum    = r_t + TW'(r_x[PBITS-1:0]) * TW'(r_b);
        w_qp     = {{PBITS{1'b0}}, w_sum[PBITS-1:0]} * {{PBITS{1'b0}}, r_minv};
        w_q      = w_qp[PBITS-1:0];
        w_sum2   = w_sum + TW'(w_q) * w_m_ext;
        w_t_next = {{PBITS{1'b0}}, w_sum2[TW-1:PBITS]};
        w_red    = (w_t_next >= w_m_ext) ? (w_t_next - w_m_ext) : w_t_next;
    end

    assign w_unused = ^{m_inv[NBITS-1:PBITS], w_qp[2*PBITS-1:PBITS],
                        w_sum2[PBITS-1:0], w_red[TW-1:NBITS]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_x    <= '0;
            r_b    <= '0;
            r_m    <= '0;
            r_y    <= '0;
            r_minv <= '0;
            r_t    <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_run && enable_p) begin
                r_run  <= 1'b1;
                r_cnt  <= '0;
                r_x    <= a;
                r_b    <= b;
                r_m    <= m;
                r_minv <= m_inv[PBITS-1:0];
                r_t    <= '0;
            end else if (r_run) begin
                r_t   <= w_t_next;
                r_x   <= r_x >> PBITS;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    r_run  <= 1'b0;
                    r_y    <= w_red[NBITS-1:0];
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign y          = r_y;
    assign done_irq_p = r_done;

endmodule

// File: rtl/montgomery_seq_wrap.sv
// Sequential Montgomery wrapper sharing one montgomery_mul for every step.
// Define MONT_SEQ_SQR_SKIP_EN to skip CONV_B in full mode when a == b.
module montgomery_seq_wrap
    import montgomery_seq_wrap_pkg::*;
#(
    parameter int NBITS = 2048,
    parameter int PBITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic             mode,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    input  logic [NBITS-1:0] m_inv,
    input  logic [NBITS-1:0] r_red,
    output logic [NBITS-1:0] y,
    output logic             busy,
    output logic             done_irq_p,
    output logic [2:0]       o_dbg_state
);

    // Handshake: enable_p is a one-cycle request honoured only in IDLE;
    // done_irq_p is a one-cycle completion pulse, and y is valid from it on.
    state_t r_state;
    state_t w_next;

    logic             r_mode;
    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;
    logic [NBITS-1:0] r_m;
    logic [NBITS-1:0] r_minv;
    logic [NBITS-1:0] r_rred;
    logic [NBITS-1:0] r_ac;
    logic [NBITS-1:0] r_bc;
    logic [NBITS-1:0] r_p;
    logic [NBITS-1:0] r_y;
    logic             r_core_en;

    logic             w_core_start;
    logic             w_accept;
    logic             w_sqr;
    logic [NBITS-1:0] w_core_x;
    logic [NBITS-1:0] w_core_y;
    logic [NBITS-1:0] w_core_res;
    logic             w_core_done;

`ifdef MONT_SEQ_SQR_SKIP_EN
    assign w_sqr = (r_a == r_b);
`else
    assign w_sqr = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && enable_p;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (enable_p)    w_next = (mode == MODE_RAW) ? ST_MUL : ST_CONV_A;
            ST_CONV_A: if (w_core_done) w_next = w_sqr ? ST_MUL : ST_CONV_B;
            ST_CONV_B: if (w_core_done) w_next = ST_MUL;
            ST_MUL:    if (w_core_done) w_next = (r_mode == MODE_FULL) ? ST_FROM : ST_DONE;
            ST_FROM:   if (w_core_done) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // One core pulse on every entry into a compute state.
    always_comb begin
        w_core_start = (w_next != r_state) &&
                       ((w_next == ST_CONV_A) || (w_next == ST_CONV_B) ||
                        (w_next == ST_MUL)    || (w_next == ST_FROM));
    end

    always_comb begin
        w_core_x = r_a;
        w_core_y = r_b;
        case (r_state)
            ST_CONV_A: begin w_core_x = r_a;  w_core_y = r_rred; end
            ST_CONV_B: begin w_core_x = r_b;  w_core_y = r_rred; end
            ST_MUL: begin
                if (r_mode == MODE_FULL) begin
                    w_core_x = r_ac;
                    w_core_y = r_bc;
                end
            end
            ST_FROM:   begin w_core_x = r_p;  w_core_y = NBITS'(1); end
            default:   begin w_core_x = r_a;  w_core_y = r_b;    end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_core_en <= 1'b0;
            r_mode    <= MODE_FULL;
            r_a       <= '0;
            r_b       <= '0;
            r_m       <= '0;
            r_minv    <= '0;
            r_rred    <= '0;
            r_ac      <= '0;
            r_bc      <= '0;
            r_p       <= '0;
            r_y       <= '0;
        end else begin
            r_state   <= w_next;
            r_core_en <= w_core_start;
            if (w_accept) begin
                r_mode <= mode;
                r_a    <= a;
                r_b    <= b;
                r_m    <= m;
                r_minv <= m_inv;
                r_rred <= r_red;
            end
            if (w_core_done) begin
                case (r_state)
                    ST_CONV_A: begin
                        r_ac <= w_core_res;
                        if (w_sqr) r_bc <= w_core_res;
                    end
                    ST_CONV_B: r_bc <= w_core_res;
                    ST_MUL: begin
                        if (r_mode == MODE_RAW) r_y <= w_core_res;
                        else                    r_p <= w_core_res;
                    end
                    ST_FROM:   r_y <= w_core_res;
                    default:   ;
                endcase
            end
        end
    end

    montgomery_mul #(
        .NBITS (NBITS),
        .PBITS (PBITS)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_p   (r_core_en),
        .a          (w_core_x),
        .b          (w_core_y),
        .m          (r_m),
        .m_inv      (r_minv),
        .y          (w_core_res),
        .done_irq_p (w_core_done)
    );

    assign y           = r_y;
    assign busy        = (r_state != ST_IDLE);
    assign done_irq_p  = (r_state == ST_DONE);
    assign o_dbg_state = r_state;

endmodule
